edc_scrub_arbiter: RTL and testbench

Background memory scrubber and bus arbiter placed between the Wishbone interconnect and the ECC-protected memory module. It forwards CPU/bus cycles to the memory with priority. In idle slots it walks a configured address window, reading each 128-bit line and writing the corrected data back, which regenerates its ECC. Uncorrectable lines are not written back; they are counted and their address is latched for software.

---
 rtl/edc_scrub_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_edc_scrub_arbiter.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edc_scrub_arbiter.sv
`timescale 1ns/1ps
// edc_scrub_arbiter: forwards Wishbone cycles from the interconnect to the
// ECC memory. In idle slots it scrubs a window of lines by reading each one
// and writing the corrected data back. A line whose read reports an error is
// skipped, with no write-back.
// Optional feature macro: EDC_SCRUB_LOG_EN builds the uncorrectable-line log
// (count, last address, sticky valid). Without it the log outputs are tied 0.
module edc_scrub_arbiter #(
  parameter int          WB_DWIDTH      = 128,
  parameter int          WB_SWIDTH      = 16,
  parameter logic [31:0] SCRUB_BASE     = 32'h0000_0000,
  parameter int          SCRUB_LINES    = 1024,
  parameter int          SCRUB_INTERVAL = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [31:0]          s_wb_adr,
  input  logic [WB_SWIDTH-1:0] s_wb_sel,
  input  logic                 s_wb_we,
  input  logic [WB_DWIDTH-1:0] s_wb_dat_w,
  input  logic                 s_wb_cyc,
  input  logic                 s_wb_stb,
  output logic [WB_DWIDTH-1:0] s_wb_dat_r,
  output logic                 s_wb_ack,
  output logic                 s_wb_err,
  output logic [31:0]          m_wb_adr,
  output logic [WB_SWIDTH-1:0] m_wb_sel,
  output logic                 m_wb_we,
  output logic [WB_DWIDTH-1:0] m_wb_dat_w,
  output logic                 m_wb_cyc,
  output logic                 m_wb_stb,
  input  logic [WB_DWIDTH-1:0] m_wb_dat_r,
  input  logic                 m_wb_ack,
  input  logic                 m_wb_err,
  input  logic                 i_scrub_enable,
  input  logic                 i_scrub_clr,
  output logic                 o_scrub_busy,
  output logic                 o_scrub_pass,
  output logic [15:0]          o_scrub_err_cnt,
  output logic [31:0]          o_scrub_err_adr,
  output logic                 o_scrub_err_vld
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CPU  = 2'd1;
  localparam logic [1:0] ST_SRD  = 2'd2;
  localparam logic [1:0] ST_SWR  = 2'd3;

  localparam logic [31:0] STRIDE    = 32'(WB_DWIDTH / 8);
  localparam logic [31:0] SCRUB_END = SCRUB_BASE + 32'(SCRUB_LINES) * STRIDE;
  localparam int          CNT_W     = $clog2(SCRUB_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCRUB_INTERVAL - 1);

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [CNT_W-1:0]     ivl_cnt;
  logic                 pending;
  logic [31:0]          scrub_adr;
  logic [31:0]          adr_inc;
  logic                 adr_wrap;
  logic [WB_DWIDTH-1:0] line_buf;
  logic                 line_bad;
  logic                 scrub_done;

  // An errored read ends the scrub early; a write ack ends it normally.
  assign line_bad   = (state == ST_SRD) && m_wb_ack && m_wb_err;
  assign scrub_done = line_bad || ((state == ST_SWR) && m_wb_ack);
  assign adr_inc    = scrub_adr + STRIDE;
  assign adr_wrap   = (adr_inc == SCRUB_END);
  assign o_scrub_busy = (state == ST_SRD) || (state == ST_SWR);

  // Next-state selection; the CPU beats a pending scrub when both are waiting.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (s_wb_cyc && s_wb_stb) state_nxt = ST_CPU;
        else if (pending)         state_nxt = ST_SRD;
      end
      ST_CPU:  if (!s_wb_cyc) state_nxt = ST_IDLE;
      ST_SRD:  if (m_wb_ack)  state_nxt = m_wb_err ? ST_IDLE : ST_SWR;
      ST_SWR:  if (m_wb_ack)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset drops the bus and abandons any line in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Interval counter raises a scrub request; finishing a scrub retires it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ivl_cnt <= '0;
      pending <= 1'b0;
    end else if (!i_scrub_enable) begin
      ivl_cnt <= '0;
      pending <= 1'b0;
    end else begin
      if (ivl_cnt == CNT_LAST) begin
        ivl_cnt <= '0;
        pending <= 1'b1;
      end else begin
        ivl_cnt <= ivl_cnt + 1'b1;
      end
      if (scrub_done) pending <= 1'b0;
    end
  end

  // Scrub address walks the window and wraps with a one-cycle pass pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scrub_adr    <= SCRUB_BASE;
      o_scrub_pass <= 1'b0;
    end else begin
      o_scrub_pass <= 1'b0;
      if (scrub_done) begin
        if (adr_wrap) begin
          scrub_adr    <= SCRUB_BASE;
          o_scrub_pass <= 1'b1;
        end else begin
          scrub_adr <= adr_inc;
        end
      end
    end
  end

  // Line buffer captures the corrected read data for the write-back.
  always_ff @(posedge i_clk) begin
    if ((state == ST_SRD) && m_wb_ack && !m_wb_err) line_buf <= m_wb_dat_r;
  end

  // Bus steering: pass-through for the CPU, scrub cycles otherwise, else quiet.
  always_comb begin
    m_wb_adr   = '0;
    m_wb_sel   = '0;
    m_wb_we    = 1'b0;
    m_wb_dat_w = '0;
    m_wb_cyc   = 1'b0;
    m_wb_stb   = 1'b0;
    s_wb_dat_r = '0;
    s_wb_ack   = 1'b0;
    s_wb_err   = 1'b0;
    case (state)
      ST_CPU: begin
        m_wb_adr   = s_wb_adr;
        m_wb_sel   = s_wb_sel;
        m_wb_we    = s_wb_we;
        m_wb_dat_w = s_wb_dat_w;
        m_wb_cyc   = s_wb_cyc;
        m_wb_stb   = s_wb_stb;
        s_wb_dat_r = m_wb_dat_r;
        s_wb_ack   = m_wb_ack;
        s_wb_err   = m_wb_err;
      end
      ST_SRD: begin
        m_wb_adr = scrub_adr;
        m_wb_sel = '1;
        m_wb_cyc = 1'b1;
        m_wb_stb = 1'b1;
      end
      ST_SWR: begin
        m_wb_adr   = scrub_adr;
        m_wb_sel   = '1;
        m_wb_we    = 1'b1;
        m_wb_dat_w = line_buf;
        m_wb_cyc   = 1'b1;
        m_wb_stb   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef EDC_SCRUB_LOG_EN
  logic [15:0] err_cnt;
  logic [31:0] err_adr;
  logic        err_vld;

  // Error log: a bad line outranks a simultaneous software clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt <= '0;
      err_adr <= '0;
      err_vld <= 1'b0;
    end else if (line_bad) begin
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      err_adr <= scrub_adr;
      err_vld <= 1'b1;
    end else if (i_scrub_clr) begin
      err_cnt <= '0;
      err_adr <= '0;
      err_vld <= 1'b0;
    end
  end

  assign o_scrub_err_cnt = err_cnt;
  assign o_scrub_err_adr = err_adr;
  assign o_scrub_err_vld = err_vld;
`else
  logic unused_clr;
  assign unused_clr      = i_scrub_clr;
  assign o_scrub_err_cnt = '0;
  assign o_scrub_err_adr = '0;
  assign o_scrub_err_vld = 1'b0;
`endif

endmodule

// File: tb/tb_edc_scrub_arbiter.sv
`timescale 1ns/1ps
// Bench for edc_scrub_arbiter: small window and interval, randomized line
// data and memory latency, expectations from a line-walk model.
module tb_edc_scrub_arbiter;
  localparam int          DW    = 128;
  localparam int          SW    = 16;
  localparam int          LINES = 4;
  localparam int          IVL   = 16;
  localparam logic [31:0] BASE  = 32'h0;

  typedef struct packed {
    logic        scrub;
    logic        we;
    logic [31:0] adr;
    logic [DW-1:0] dat;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0]   s_wb_adr = '0;
  logic [SW-1:0] s_wb_sel = '0;
  logic          s_wb_we = 1'b0;
  logic [DW-1:0] s_wb_dat_w = '0;
  logic          s_wb_cyc = 1'b0;
  logic          s_wb_stb = 1'b0;
  logic [DW-1:0] s_wb_dat_r;
  logic          s_wb_ack;
  logic          s_wb_err;
  logic [31:0]   m_wb_adr;
  logic [SW-1:0] m_wb_sel;
  logic          m_wb_we;
  logic [DW-1:0] m_wb_dat_w;
  logic          m_wb_cyc;
  logic          m_wb_stb;
  logic [DW-1:0] m_wb_dat_r = '0;
  logic          m_wb_ack = 1'b0;
  logic          m_wb_err = 1'b0;
  logic          scrub_en = 1'b0;
  logic          scrub_clr = 1'b0;
  logic          busy;
  logic          pass;
  logic [15:0]   err_cnt;
  logic [31:0]   err_adr;
  logic          err_vld;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int lines_done = 0;

  logic [DW-1:0] mem [32];
  logic [DW-1:0] ref_mem [32];
  bit            sbe [32];
  bit            dbe [32];
  op_t           ops [$];
  int            starts [$];
  logic [31:0]   pass_adr [$];
  logic [31:0]   last_done_adr = '0;
  logic          busy_d = 1'b0;

  edc_scrub_arbiter #(
    .WB_DWIDTH(DW), .WB_SWIDTH(SW), .SCRUB_BASE(BASE),
    .SCRUB_LINES(LINES), .SCRUB_INTERVAL(IVL)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .s_wb_adr(s_wb_adr), .s_wb_sel(s_wb_sel), .s_wb_we(s_wb_we),
    .s_wb_dat_w(s_wb_dat_w), .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb),
    .s_wb_dat_r(s_wb_dat_r), .s_wb_ack(s_wb_ack), .s_wb_err(s_wb_err),
    .m_wb_adr(m_wb_adr), .m_wb_sel(m_wb_sel), .m_wb_we(m_wb_we),
    .m_wb_dat_w(m_wb_dat_w), .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb),
    .m_wb_dat_r(m_wb_dat_r), .m_wb_ack(m_wb_ack), .m_wb_err(m_wb_err),
    .i_scrub_enable(scrub_en), .i_scrub_clr(scrub_clr),
    .o_scrub_busy(busy), .o_scrub_pass(pass),
    .o_scrub_err_cnt(err_cnt), .o_scrub_err_adr(err_adr), .o_scrub_err_vld(err_vld)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // Expected address of the n-th line scrubbed since reset.
  function automatic logic [31:0] line_adr(input int n);
    return BASE + 32'(n % LINES) * 32'(DW / 8);
  endfunction

  // ECC memory model: random ack latency, corrected reads, err on double-bit lines.
  initial begin
    bit       armed;
    int       wait_cnt;
    logic [4:0] idx;
    op_t      rec;
    armed = 0;
    wait_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0; ref_mem[i] = '0; sbe[i] = 0; dbe[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && busy_d === 1'b0) starts.push_back(cyc_n);
      busy_d = busy;
      if (pass === 1'b1) pass_adr.push_back(last_done_adr);
      if (m_wb_ack) begin
        m_wb_ack = 1'b0;
        m_wb_err = 1'b0;
      end else if (m_wb_cyc === 1'b1 && m_wb_stb === 1'b1) begin
        if (!armed) begin
          armed = 1;
          wait_cnt = int'($urandom_range(0, 2));
        end
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          armed = 0;
          idx = m_wb_adr[8:4];
          rec.scrub = busy;
          rec.we = m_wb_we;
          rec.adr = m_wb_adr;
          if (m_wb_we) begin
            for (int b = 0; b < SW; b++)
              if (m_wb_sel[b]) mem[idx][b*8 +: 8] = m_wb_dat_w[b*8 +: 8];
            sbe[idx] = 0;
            dbe[idx] = 0;
            m_wb_err = 1'b0;
            rec.dat = m_wb_dat_w;
            if (busy) last_done_adr = m_wb_adr;
          end else begin
            m_wb_dat_r = mem[idx];
            m_wb_err = dbe[idx];
            rec.dat = mem[idx];
            if (busy && dbe[idx]) last_done_adr = m_wb_adr;
          end
          ops.push_back(rec);
          m_wb_ack = 1'b1;
        end
      end else begin
        armed = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_raise(input logic we, input logic [31:0] adr, input logic [DW-1:0] dat);
    s_wb_adr = adr;
    s_wb_we = we;
    s_wb_sel = '1;
    s_wb_dat_w = dat;
    s_wb_cyc = 1'b1;
    s_wb_stb = 1'b1;
  endtask

  task automatic cpu_wait(output logic [DW-1:0] rd, output logic er, output bit ok,
                          output bit ack_busy);
    ok = 0;
    ack_busy = 0;
    rd = '0;
    er = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (s_wb_ack === 1'b1) begin
        ok = 1;
        rd = s_wb_dat_r;
        er = s_wb_err;
        if (busy) ack_busy = 1;
      end
    end
    s_wb_cyc = 1'b0;
    s_wb_stb = 1'b0;
    s_wb_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({m_wb_cyc, m_wb_stb, m_wb_we} !== 3'b000) begin
      bad++; $display("FAIL reset_m_ctrl got=%b want=000", {m_wb_cyc, m_wb_stb, m_wb_we});
    end
    total++;
    if ({m_wb_adr, m_wb_sel, m_wb_dat_w} !== '0) begin
      bad++; $display("FAIL reset_m_data got=%h want=0", {m_wb_adr, m_wb_sel, m_wb_dat_w});
    end
    total++;
    if ({s_wb_ack, s_wb_err, s_wb_dat_r} !== '0) begin
      bad++; $display("FAIL reset_s_resp got=%h want=0", {s_wb_ack, s_wb_err, s_wb_dat_r});
    end
    total++;
    if ({busy, pass, err_cnt, err_adr, err_vld} !== '0) begin
      bad++; $display("FAIL reset_scrub_out got=%h want=0", {busy, pass, err_cnt, err_adr, err_vld});
    end
    rst_n = 1'b1;
    lines_done = 0;
    repeat (2) tick();
    total++;
    if (m_wb_cyc !== 1'b0) begin
      bad++; $display("FAIL reset_idle_cyc got=%b want=0", m_wb_cyc);
    end
  endtask

  task automatic test_cpu_write();
    logic [DW-1:0] data;
    bit ok;
    data = {$urandom, $urandom, $urandom, 32'hDEADBEEF};
    starts.delete();
    cpu_raise(1'b1, 32'h100, data);
    total++;
    if (m_wb_cyc !== 1'b0) begin
      bad++; $display("FAIL cpu_grant_early m_wb_cyc=%b want=0", m_wb_cyc);
    end
    tick();
    total++;
    if ({m_wb_cyc, m_wb_stb, m_wb_we, m_wb_adr, m_wb_sel} !== {3'b111, 32'h100, 16'hFFFF}) begin
      bad++; $display("FAIL cpu_mirror_ctrl got=%h want=%h", {m_wb_cyc, m_wb_stb, m_wb_we, m_wb_adr, m_wb_sel},
                      {3'b111, 32'h100, 16'hFFFF});
    end
    total++;
    if (m_wb_dat_w !== data) begin
      bad++; $display("FAIL cpu_mirror_dat got=%h want=%h", m_wb_dat_w, data);
    end
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      total++;
      if (s_wb_ack !== m_wb_ack) begin
        bad++; $display("FAIL cpu_ack_follow s_wb_ack=%b m_wb_ack=%b", s_wb_ack, m_wb_ack);
      end
      if (m_wb_ack === 1'b1) ok = 1;
      else tick();
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL cpu_write_timeout got=no_ack want=ack");
    end
    s_wb_cyc = 1'b0;
    s_wb_stb = 1'b0;
    s_wb_we = 1'b0;
    repeat (3) tick();
    total++;
    if (mem[16] !== data) begin
      bad++; $display("FAIL cpu_write_mem got=%h want=%h", mem[16], data);
    end
    total++;
    if ({m_wb_cyc, starts.size()} !== {1'b0, 32'd0}) begin
      bad++; $display("FAIL cpu_no_scrub cyc=%b scrubs=%0d want 0/0", m_wb_cyc, starts.size());
    end
    ref_mem[16] = data;
  endtask

  task automatic test_scrub_walk();
    op_t sq [$];
    int  n;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    lines_done = 0;
    for (int i = 0; i < LINES; i++) begin
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i] = mem[i];
      sbe[i] = 0;
      dbe[i] = 0;
    end
    ops.delete(); starts.delete(); pass_adr.delete();
    scrub_en = 1'b1;
    repeat (95) tick();
    scrub_en = 1'b0;
    repeat (10) tick();
    total++;
    if (starts.size() != LINES + 1) begin
      bad++; $display("FAIL walk_scrub_count got=%0d want=%0d", starts.size(), LINES + 1);
    end
    for (int i = 1; i < starts.size(); i++) begin
      total++;
      if (starts[i] - starts[i-1] != IVL) begin
        bad++; $display("FAIL walk_spacing idx=%0d got=%0d want=%0d", i, starts[i] - starts[i-1], IVL);
      end
    end
    foreach (ops[i]) if (ops[i].scrub) sq.push_back(ops[i]);
    total++;
    if (sq.size() != 2 * (LINES + 1)) begin
      bad++; $display("FAIL walk_op_count got=%0d want=%0d", sq.size(), 2 * (LINES + 1));
    end
    for (int i = 0; i < sq.size() && i < 2 * (LINES + 1); i++) begin
      n = i / 2;
      total++;
      if ({sq[i].we, sq[i].adr, sq[i].dat} !== {1'(i % 2), line_adr(n), ref_mem[n % LINES]}) begin
        bad++; $display("FAIL walk_op idx=%0d got we=%b adr=%h dat=%h want we=%0d adr=%h dat=%h", i,
                        sq[i].we, sq[i].adr, sq[i].dat, i % 2, line_adr(n), ref_mem[n % LINES]);
      end
    end
    total++;
    if (pass_adr.size() != 1 || pass_adr[0] !== line_adr(LINES - 1)) begin
      bad++; $display("FAIL walk_pass pulses=%0d after_adr=%h want 1 after %h", pass_adr.size(),
                      (pass_adr.size() > 0) ? pass_adr[0] : 32'hFFFF_FFFF, line_adr(LINES - 1));
    end
    lines_done = LINES + 1;
  endtask

  task automatic run_one_scrub(output op_t sq [$]);
    ops.delete(); starts.delete();
    scrub_en = 1'b1;
    repeat (26) tick();
    scrub_en = 1'b0;
    repeat (4) tick();
    foreach (ops[i]) if (ops[i].scrub) sq.push_back(ops[i]);
  endtask

  task automatic test_single_bit();
    op_t sq [$];
    logic [31:0] a;
    logic [DW-1:0] rd;
    logic er;
    bit ok, ab;
    int li;
    a = line_adr(lines_done);
    li = lines_done % LINES;
    sbe[li] = 1;
    run_one_scrub(sq);
    total++;
    if (sq.size() != 2) begin
      bad++; $display("FAIL sbe_op_count got=%0d want=2", sq.size());
    end else begin
      total++;
      if ({sq[0].we, sq[0].adr, sq[1].we, sq[1].adr, sq[1].dat} !== {1'b0, a, 1'b1, a, ref_mem[li]}) begin
        bad++; $display("FAIL sbe_rmw got r=%h w=%h dat=%h want adr=%h dat=%h", sq[0].adr, sq[1].adr,
                        sq[1].dat, a, ref_mem[li]);
      end
    end
    total++;
    if (sbe[li] != 0) begin
      bad++; $display("FAIL sbe_writeback flag=%0d want=0", sbe[li]);
    end
    lines_done++;
    cpu_raise(1'b0, a, '0);
    cpu_wait(rd, er, ok, ab);
    total++;
    if ({ok, er, rd} !== {1'b1, 1'b0, ref_mem[li]}) begin
      bad++; $display("FAIL sbe_cpu_read ok=%0d err=%b dat=%h want ok=1 err=0 dat=%h", ok, er, rd, ref_mem[li]);
    end
  endtask

  task automatic test_double_bit();
    op_t sq [$];
    logic [31:0] a;
    logic [15:0] exp_cnt;
    logic [31:0] exp_adr;
    logic        exp_vld;
    int li;
    a = line_adr(lines_done);
    li = lines_done % LINES;
    dbe[li] = 1;
    run_one_scrub(sq);
    total++;
    if (sq.size() != 1) begin
      bad++; $display("FAIL dbe_op_count got=%0d want=1", sq.size());
    end else begin
      total++;
      if ({sq[0].we, sq[0].adr} !== {1'b0, a}) begin
        bad++; $display("FAIL dbe_read got we=%b adr=%h want we=0 adr=%h", sq[0].we, sq[0].adr, a);
      end
    end
    lines_done++;
`ifdef EDC_SCRUB_LOG_EN
    exp_cnt = 16'd1; exp_adr = a; exp_vld = 1'b1;
`else
    exp_cnt = 16'd0; exp_adr = 32'd0; exp_vld = 1'b0;
`endif
    total++;
    if ({err_cnt, err_adr, err_vld} !== {exp_cnt, exp_adr, exp_vld}) begin
      bad++; $display("FAIL dbe_log got cnt=%0d adr=%h vld=%b want cnt=%0d adr=%h vld=%b",
                      err_cnt, err_adr, err_vld, exp_cnt, exp_adr, exp_vld);
    end
    scrub_clr = 1'b1;
    tick();
    scrub_clr = 1'b0;
    tick();
    total++;
    if ({err_cnt, err_adr, err_vld} !== '0) begin
      bad++; $display("FAIL dbe_clear got cnt=%0d adr=%h vld=%b want all 0", err_cnt, err_adr, err_vld);
    end
  endtask

  task automatic test_priority();
    logic [DW-1:0] d2, rd;
    logic er;
    bit ok, ab;
    int k, base_n;
    d2 = {$urandom, $urandom, $urandom, $urandom};
    ops.delete(); starts.delete();
    scrub_en = 1'b1;
    for (int i = 0; i < 40 && starts.size() == 0; i++) tick();
    total++;
    if (starts.size() == 0) begin
      bad++; $display("FAIL prio_first_scrub got=none want=start");
      scrub_en = 1'b0;
      return;
    end
    k = starts[0];
    for (int i = 0; i < 40 && cyc_n < k + IVL - 1; i++) tick();
    cpu_raise(1'b1, 32'h100, d2);
    tick();
    total++;
    if ({m_wb_cyc, busy, m_wb_adr} !== {1'b1, 1'b0, 32'h100}) begin
      bad++; $display("FAIL prio_cpu_first got cyc=%b busy=%b adr=%h want 1/0/100", m_wb_cyc, busy, m_wb_adr);
    end
    cpu_wait(rd, er, ok, ab);
    total++;
    if (!ok) begin
      bad++; $display("FAIL prio_cpu_ack got=no_ack want=ack");
    end
    for (int i = 0; i < 40 && ops.size() < 5; i++) tick();
    total++;
    if (ops.size() < 5) begin
      bad++; $display("FAIL prio_ops got=%0d want>=5", ops.size());
    end else begin
      total++;
      if ({ops[2].scrub, ops[2].we, ops[2].adr, ops[3].scrub, ops[3].we, ops[3].adr} !==
          {2'b01, 32'h100, 2'b10, line_adr(lines_done + 1)}) begin
        bad++; $display("FAIL prio_order got cpu=%b%b%h next=%b%b%h want 01/100 then 10/%h",
                        ops[2].scrub, ops[2].we, ops[2].adr, ops[3].scrub, ops[3].we, ops[3].adr,
                        line_adr(lines_done + 1));
      end
    end
    lines_done += 2;
    for (int i = 0; i < 40 && !(busy === 1'b1 && m_wb_we === 1'b0); i++) tick();
    base_n = lines_done;
    cpu_raise(1'b0, 32'h100, '0);
    cpu_wait(rd, er, ok, ab);
    total++;
    if ({ok, ab, rd} !== {1'b1, 1'b0, d2}) begin
      bad++; $display("FAIL prio_held ok=%0d ack_in_scrub=%0d dat=%h want 1/0/%h", ok, ab, rd, d2);
    end
    total++;
    if (ops.size() < 2 ||
        {ops[ops.size()-2].scrub, ops[ops.size()-2].we, ops[ops.size()-2].adr,
         ops[ops.size()-1].scrub, ops[ops.size()-1].we} !== {2'b11, line_adr(base_n), 2'b00}) begin
      bad++; $display("FAIL prio_atomic ops=%0d want scrub write %h then cpu read", ops.size(), line_adr(base_n));
    end
    lines_done++;
    scrub_en = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_swr();
    int n_ops;
    scrub_en = 1'b1;
    for (int i = 0; i < 40 && !(busy === 1'b1 && m_wb_we === 1'b1); i++) tick();
    total++;
    if (!(busy === 1'b1 && m_wb_we === 1'b1)) begin
      bad++; $display("FAIL rst_swr_reach got busy=%b we=%b want 1/1", busy, m_wb_we);
    end
    n_ops = ops.size();
    rst_n = 1'b0;
    #1;
    total++;
    if ({m_wb_cyc, m_wb_stb, busy} !== 3'b000) begin
      bad++; $display("FAIL rst_swr_drop got=%b want=000", {m_wb_cyc, m_wb_stb, busy});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    lines_done = 0;
    total++;
    if ({m_wb_cyc, m_wb_stb, m_wb_we, m_wb_adr, m_wb_dat_w, s_wb_ack, s_wb_dat_r, busy, pass,
         err_cnt, err_vld} !== '0) begin
      bad++; $display("FAIL rst_swr_outputs cyc=%b adr=%h busy=%b pass=%b want all 0", m_wb_cyc, m_wb_adr, busy, pass);
    end
    total++;
    if (ops.size() != n_ops) begin
      bad++; $display("FAIL rst_swr_nowrite ops=%0d want=%0d", ops.size(), n_ops);
    end
    for (int i = 0; i < 40 && ops.size() == n_ops; i++) tick();
    total++;
    if (ops.size() == n_ops || {ops[n_ops].scrub, ops[n_ops].we, ops[n_ops].adr} !== {2'b10, BASE}) begin
      bad++; $display("FAIL rst_swr_restart ops=%0d want scrub read at %h", ops.size(), BASE);
    end
    scrub_en = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_scrub_walk();
    test_single_bit();
    test_double_bit();
    test_priority();
    test_reset_swr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
